pair_sched: RTL and testbench

- Sequencer at the front of the connection-sort datapath.
- On `start`, enumerates every unordered point pair (a,b) with a<b for the configured point count and issues them, one per cycle, to the distance pipeline under ready/valid handshake.
- After the last pair has cleared the fixed-latency distance pipeline, raises `dist_done` so the insertion sorter can begin draining.
- Reports progress (pair count, busy) to the top-level control.

---
 rtl/pair_sched.sv | 101 ++++++++++
 tb/tb_pair_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pair_sched.sv
// Point-pair sequencer: walks every (a,b) with a<b for the configured count,
// hands pairs to the distance pipeline, then flags when that pipeline has drained.
module pair_sched #(
  parameter int NUM_POINTS = 1000,
  parameter int DIST_LAT   = 4,
  localparam int PT_W  = $clog2(NUM_POINTS),
  localparam int CNT_W = $clog2(NUM_POINTS*(NUM_POINTS-1)/2+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PT_W:0]    num_points_cfg,
  output logic [PT_W-1:0]  pair_a,
  output logic [PT_W-1:0]  pair_b,
  output logic             pair_vld,
  input  logic             pair_rdy,
  output logic             dist_done,
  output logic             busy,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam int DW = (DIST_LAT > 1) ? $clog2(DIST_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [PT_W:0]   n_clamp;
  logic [PT_W-1:0] last_b;
  logic [DW-1:0]   drain;
  logic            last_pair;

  always_comb begin
    n_clamp = num_points_cfg;
    if (num_points_cfg > (PT_W+1)'(NUM_POINTS))
      n_clamp = (PT_W+1)'(NUM_POINTS);
  end

  // Final pair is (N-2, N-1); b at N-1 with a one below it.
  assign last_pair = (pair_b == last_b) &&
                     (PT_W'(pair_a + 1'b1) == last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pair_a    <= '0;
      pair_b    <= '0;
      pair_vld  <= 1'b0;
      dist_done <= 1'b0;
      busy      <= 1'b0;
      pair_cnt  <= '0;
      last_b    <= '0;
      drain     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            pair_cnt  <= '0;
            last_b    <= PT_W'(n_clamp - 1'b1);
            if (n_clamp >= (PT_W+1)'(2)) begin
              state     <= ISSUE;
              pair_a    <= '0;
              pair_b    <= PT_W'(1);
              pair_vld  <= 1'b1;
              busy      <= 1'b1;
              dist_done <= 1'b0;
            end else begin
              state     <= DONE;
              dist_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (pair_rdy) begin
            pair_cnt <= pair_cnt + 1'b1;
            if (last_pair) begin
              pair_vld <= 1'b0;
              state    <= DRAIN;
              drain    <= DW'(DIST_LAT - 1);
            end else if (pair_b != last_b) begin
              pair_b <= pair_b + 1'b1;
            end else begin
              pair_a <= pair_a + 1'b1;
              pair_b <= pair_a + PT_W'(2);
            end
          end
        end
        DRAIN: begin
          if (drain == '0) begin
            state     <= DONE;
            dist_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            drain <= drain - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_sched.sv
// Directed bench for pair_sched: vector table of enumeration runs plus
// reset-during-issue sequence, built with NUM_POINTS=20, DIST_LAT=4.
module tb_pair_sched;

  localparam int NP  = 20;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] num_points_cfg;
  logic [4:0] pair_a;
  logic [4:0] pair_b;
  logic       pair_vld;
  logic       pair_rdy;
  logic       dist_done;
  logic       busy;
  logic [7:0] pair_cnt;

  int total  = 0;
  int passed = 0;

  typedef struct {
    int n;
    int mode;
    int restart;
    int exp_cnt;
    int exp_la;
    int exp_lb;
  } vec_t;

  vec_t vecs[8];

  pair_sched #(.NUM_POINTS(NP), .DIST_LAT(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_points_cfg (num_points_cfg),
    .pair_a         (pair_a),
    .pair_b         (pair_b),
    .pair_vld       (pair_vld),
    .pair_rdy       (pair_rdy),
    .dist_done      (dist_done),
    .busy           (busy),
    .pair_cnt       (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int nm, ea, eb, xfers, last_t, done_c, la, lb;
    nm = (v.n > NP) ? NP : v.n;
    ea = 0; eb = 1; xfers = 0; last_t = 0;
    done_c = -1; la = -1; lb = -1;
    @(posedge clk); #1;
    start = 1'b1;
    num_points_cfg = 6'(v.n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      start = (v.restart != 0 && c == v.restart);
      if (start) num_points_cfg = 6'd3;
      if (v.mode == 0) pair_rdy = 1'b1;
      else pair_rdy = ((c-1) % 4 == 0) || ((c-1) % 4 == 3);
      @(negedge clk);
      if (c == 1) begin
        chk("cnt_clear", pair_cnt, 0);
        chk("done_after_start", dist_done, int'(nm < 2));
      end
      if (dist_done) done_c = c;
      else chk("busy", busy, 1);
      if (pair_vld) begin
        chk("vld_in_range", int'(xfers < v.exp_cnt), 1);
        chk("pair_a", pair_a, ea);
        chk("pair_b", pair_b, eb);
        if (pair_rdy) begin
          xfers++;
          last_t = c;
          la = ea; lb = eb;
          if (eb < nm - 1) eb++;
          else begin
            ea++;
            eb = ea + 1;
          end
        end
      end
    end
    start = 1'b0;
    chk("done_seen", int'(done_c >= 0), 1);
    chk("xfers", xfers, v.exp_cnt);
    chk("pair_cnt", pair_cnt, v.exp_cnt);
    chk("done_cycle", done_c, (v.exp_cnt == 0) ? 1 : last_t + LAT + 1);
    chk("busy_done", busy, 0);
    chk("vld_done", pair_vld, 0);
    if (v.exp_cnt > 0) begin
      chk("last_a", la, v.exp_la);
      chk("last_b", lb, v.exp_lb);
    end
  endtask

  initial begin
    int found;
    vecs[0] = '{n: 4,  mode: 0, restart: 0, exp_cnt: 6,   exp_la: 2,  exp_lb: 3};
    vecs[1] = '{n: 4,  mode: 1, restart: 0, exp_cnt: 6,   exp_la: 2,  exp_lb: 3};
    vecs[2] = '{n: 1,  mode: 0, restart: 0, exp_cnt: 0,   exp_la: 0,  exp_lb: 0};
    vecs[3] = '{n: 0,  mode: 0, restart: 0, exp_cnt: 0,   exp_la: 0,  exp_lb: 0};
    vecs[4] = '{n: 25, mode: 0, restart: 0, exp_cnt: 190, exp_la: 18, exp_lb: 19};
    vecs[5] = '{n: 5,  mode: 1, restart: 3, exp_cnt: 10,  exp_la: 3,  exp_lb: 4};
    vecs[6] = '{n: 3,  mode: 0, restart: 0, exp_cnt: 3,   exp_la: 1,  exp_lb: 2};
    vecs[7] = '{n: 2,  mode: 1, restart: 0, exp_cnt: 1,   exp_la: 0,  exp_lb: 1};

    rst = 1'b1;
    start = 1'b0;
    num_points_cfg = '0;
    pair_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", pair_vld, 0);
    chk("rst_a", pair_a, 0);
    chk("rst_b", pair_b, 0);
    chk("rst_done", dist_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pair_cnt, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of issuing, at pair (1,3) of an N=4 run.
    @(posedge clk); #1;
    start = 1'b1;
    num_points_cfg = 6'd4;
    pair_rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (pair_vld && pair_a == 5'd1 && pair_b == 5'd3) found = 1;
    end
    chk("rst_pair_found", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", pair_vld, 0);
    chk("mid_rst_a", pair_a, 0);
    chk("mid_rst_b", pair_b, 0);
    chk("mid_rst_done", dist_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", pair_cnt, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_idle_vld", pair_vld, 0);
    end
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
